wb_stage_regfile: RTL and testbench

//  Write-back stage and architectural register file of the 8-bit pipelined core.

---
 rtl/wb_stage_regfile.sv | 75 +++++++
 tb/tb_wb_stage_regfile.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_regfile.sv
// Write-back stage: selects load/ALU result, commits to the register file, bypasses reads.
// Also keeps saturating retire/load counters for debug.
module wb_stage_regfile #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int CNT_W   = 16,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN,
  input  logic              MEM_R_EN,
  input  logic [DATA_W-1:0] Val_LDR,
  input  logic [DATA_W-1:0] ALU_Res,
  input  logic [ADDR_W-1:0] Dest,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_value,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  load_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] wb_sel;
  logic              we;

  assign wb_sel   = MEM_R_EN ? Val_LDR : ALU_Res;
  assign we       = WB_EN & ~(ZERO_R0 && (Dest == '0));
  assign wb_valid = we;
  assign wb_dest  = Dest;
  assign wb_value = wb_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[Dest] <= wb_sel;
    end
  end

  // The R0 zero override sits above the bypass so a dropped R0 write never leaks through.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (ZERO_R0 && (rd_addr1 == '0)) rd_data1 = '0;
    else if (we && (Dest == rd_addr1)) rd_data1 = wb_sel;
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (ZERO_R0 && (rd_addr2 == '0)) rd_data2 = '0;
    else if (we && (Dest == rd_addr2)) rd_data2 = wb_sel;
  end

  // Counters follow WB_EN, not we: a write dropped to R0 still retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
      load_cnt   <= '0;
    end else if (cnt_clr) begin
      retire_cnt <= '0;
      load_cnt   <= '0;
    end else begin
      if (WB_EN && (retire_cnt != '1)) retire_cnt <= retire_cnt + CNT_W'(1);
      if (WB_EN && MEM_R_EN && (load_cnt != '1)) load_cnt <= load_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Bench for wb_stage_regfile: reference model feeds an expectation queue, tasks pop and compare.
module tb_wb_stage_regfile;

  logic       clk, rst;
  logic       WB_EN, MEM_R_EN, cnt_clr;
  logic [7:0] Val_LDR, ALU_Res;
  logic [1:0] Dest, rd_addr1, rd_addr2;

  logic [7:0] rd1, rd2, val, rd1_z, rd2_z, val_z;
  logic       vld, vld_z;
  logic [1:0] wdst, wdst_z;
  logic [3:0] rc, lc, rc_z, lc_z;

  wb_stage_regfile #(.DATA_W(8), .ADDR_W(2), .CNT_W(4), .ZERO_R0(1'b0)) dut (
    .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .Val_LDR(Val_LDR),
    .ALU_Res(ALU_Res), .Dest(Dest), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1), .rd_data2(rd2), .wb_valid(vld), .wb_dest(wdst), .wb_value(val),
    .cnt_clr(cnt_clr), .retire_cnt(rc), .load_cnt(lc)
  );

  wb_stage_regfile #(.DATA_W(8), .ADDR_W(2), .CNT_W(4), .ZERO_R0(1'b1)) dut_z (
    .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .Val_LDR(Val_LDR),
    .ALU_Res(ALU_Res), .Dest(Dest), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_z), .rd_data2(rd2_z), .wb_valid(vld_z), .wb_dest(wdst_z), .wb_value(val_z),
    .cnt_clr(cnt_clr), .retire_cnt(rc_z), .load_cnt(lc_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d1, d2, v, d1z, d2z;
    logic       vld, vldz;
    logic [1:0] dst;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] m_regs [4];
  logic [3:0] m_rc, m_lc;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic exp_t predict();
    exp_t x;
    logic [7:0] v;
    v     = MEM_R_EN ? Val_LDR : ALU_Res;
    x.v   = v;
    x.vld = WB_EN;
    x.dst = Dest;
    x.d1  = (WB_EN && Dest == rd_addr1) ? v : m_regs[rd_addr1];
    x.d2  = (WB_EN && Dest == rd_addr2) ? v : m_regs[rd_addr2];
    // The zero-R0 variant differs only on address 0.
    x.d1z  = (rd_addr1 == 2'd0) ? 8'h00 : x.d1;
    x.d2z  = (rd_addr2 == 2'd0) ? 8'h00 : x.d2;
    x.vldz = WB_EN && (Dest != 2'd0);
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_rc = 4'h0;
    m_lc = 4'h0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (WB_EN) m_regs[Dest] = MEM_R_EN ? Val_LDR : ALU_Res;
      if (cnt_clr) begin
        m_rc = 4'h0;
        m_lc = 4'h0;
      end else begin
        if (WB_EN && m_rc != 4'hF) m_rc = m_rc + 4'h1;
        if (WB_EN && MEM_R_EN && m_lc != 4'hF) m_lc = m_lc + 4'h1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic en, input logic ld, input logic [7:0] ldr,
                       input logic [7:0] alu, input logic [1:0] dst,
                       input logic [1:0] a1, input logic [1:0] a2, input logic clr);
    WB_EN = en; MEM_R_EN = ld; Val_LDR = ldr; ALU_Res = alu; Dest = dst;
    rd_addr1 = a1; rd_addr2 = a2; cnt_clr = clr;
    #1;
    exp_q.push_back(predict());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 2'd1, 2'd2, 1'b0);
    e = exp_q.pop_front();
    tick();
    n_cmp++; if (rd1 !== 8'h00 || rd2 !== 8'h00) begin n_bad++; $display("FAIL reset_rd: got %h/%h want 00/00", rd1, rd2); end
    n_cmp++; if (rc !== 4'h0 || lc !== 4'h0) begin n_bad++; $display("FAIL reset_cnt: got %h/%h want 0/0", rc, lc); end
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 8'h55, 2'd1, 2'd1, 2'd1, 1'b0);
    e = exp_q.pop_front();
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 2'd1, 2'd1, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (rd1 !== e.d1 || rc !== m_rc) begin n_bad++; $display("FAIL pre_reset: got %h cnt %h want %h cnt %h", rd1, rc, e.d1, m_rc); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (rd1 !== 8'h00 || rc !== 4'h0 || lc !== 4'h0) begin n_bad++; $display("FAIL async_reset: got rd %h rc %h lc %h want 00 0 0", rd1, rc, lc); end
    // An edge while rst is held must not commit.
    drive(1'b1, 1'b0, 8'h00, 8'h99, 2'd2, 2'd2, 2'd2, 1'b0);
    e = exp_q.pop_front();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 2'd2, 2'd2, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (rd1 !== 8'h00 || rc !== 4'h0) begin n_bad++; $display("FAIL reset_edge_nowrite: got rd %h rc %h want 00 0", rd1, rc); end
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b0, 8'h00, 8'h3C, 2'd2, 2'd2, 2'd0, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (rd1 !== e.d1) begin n_bad++; $display("FAIL alu_bypass: got %h want %h", rd1, e.d1); end
    n_cmp++; if (vld !== e.vld || wdst !== e.dst || val !== e.v) begin n_bad++; $display("FAIL alu_tap: got %b/%h/%h want %b/%h/%h", vld, wdst, val, e.vld, e.dst, e.v); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 2'd2, 2'd2, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (rd1 !== e.d1 || e.d1 !== 8'h3C) begin n_bad++; $display("FAIL alu_commit: got %h want 3c", rd1); end
    n_cmp++; if (rc !== m_rc || lc !== m_lc) begin n_bad++; $display("FAIL alu_cnt: got %h/%h want %h/%h", rc, lc, m_rc, m_lc); end
  endtask

  task automatic test_load_write();
    drive(1'b1, 1'b1, 8'hA5, 8'h11, 2'd1, 2'd3, 2'd1, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (val !== e.v || rd2 !== e.d2) begin n_bad++; $display("FAIL load_select: got val %h rd2 %h want %h %h", val, rd2, e.v, e.d2); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 2'd1, 2'd2, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (rd1 !== e.d1 || rd2 !== e.d2) begin n_bad++; $display("FAIL load_commit: got %h/%h want %h/%h", rd1, rd2, e.d1, e.d2); end
    n_cmp++; if (lc !== m_lc || rc !== m_rc) begin n_bad++; $display("FAIL load_cnt: got lc %h rc %h want %h %h", lc, rc, m_lc, m_rc); end
  endtask

  task automatic test_gated_write();
    drive(1'b0, 1'b1, 8'hFF, 8'h22, 2'd3, 2'd3, 2'd3, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (vld !== 1'b0 || rd1 !== e.d1) begin n_bad++; $display("FAIL gated_comb: got vld %b rd %h want 0 %h", vld, rd1, e.d1); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 2'd3, 2'd3, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (rd1 !== e.d1 || rc !== m_rc || lc !== m_lc) begin n_bad++; $display("FAIL gated_state: got rd %h rc %h lc %h want %h %h %h", rd1, rc, lc, e.d1, m_rc, m_lc); end
  endtask

  task automatic test_dual_read();
    drive(1'b1, 1'b0, 8'h00, 8'h7E, 2'd0, 2'd0, 2'd0, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (rd1 !== e.d1 || rd2 !== e.d2) begin n_bad++; $display("FAIL dual_bypass: got %h/%h want %h/%h", rd1, rd2, e.d1, e.d2); end
    n_cmp++; if (rd1_z !== e.d1z || rd2_z !== e.d2z || vld_z !== e.vldz) begin n_bad++; $display("FAIL dual_zero_r0: got %h/%h vld %b want %h/%h %b", rd1_z, rd2_z, vld_z, e.d1z, e.d2z, e.vldz); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 2'd0, 2'd0, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (rd1 !== e.d1 || rd2_z !== e.d2z) begin n_bad++; $display("FAIL dual_commit: got %h/%h want %h/%h", rd1, rd2_z, e.d1, e.d2z); end
    n_cmp++; if (rc_z !== m_rc) begin n_bad++; $display("FAIL r0_drop_counts: got %h want %h", rc_z, m_rc); end
  endtask

  task automatic test_counter_sat_clear();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i[0], 8'(i), 8'(i + 100), 2'(i), 2'd0, 2'd1, 1'b0);
      e = exp_q.pop_front();
      tick();
    end
    n_cmp++; if (rc !== 4'hF || m_rc !== 4'hF) begin n_bad++; $display("FAIL retire_sat: got %h want f", rc); end
    n_cmp++; if (lc !== m_lc) begin n_bad++; $display("FAIL load_sat: got %h want %h", lc, m_lc); end
    drive(1'b1, 1'b1, 8'h01, 8'h02, 2'd3, 2'd0, 2'd0, 1'b1);
    e = exp_q.pop_front();
    tick();
    n_cmp++; if (rc !== 4'h0 || lc !== 4'h0) begin n_bad++; $display("FAIL clr_wins: got %h/%h want 0/0", rc, lc); end
    drive(1'b1, 1'b1, 8'h01, 8'h02, 2'd3, 2'd3, 2'd0, 1'b0);
    e = exp_q.pop_front();
    tick();
    n_cmp++; if (rc !== m_rc || lc !== m_lc) begin n_bad++; $display("FAIL post_clr_count: got %h/%h want %h/%h", rc, lc, m_rc, m_lc); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 8'($urandom),
            2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom_range(0, 15) == 0));
      e = exp_q.pop_front();
      n_cmp++; if (rd1 !== e.d1 || rd2 !== e.d2) begin n_bad++; $display("FAIL b2b_rd[%0d]: got %h/%h want %h/%h", i, rd1, rd2, e.d1, e.d2); end
      n_cmp++; if (val !== e.v || vld !== e.vld || wdst !== e.dst) begin n_bad++; $display("FAIL b2b_tap[%0d]: got %h/%b/%h want %h/%b/%h", i, val, vld, wdst, e.v, e.vld, e.dst); end
      n_cmp++; if (rd1_z !== e.d1z || rd2_z !== e.d2z || vld_z !== e.vldz) begin n_bad++; $display("FAIL b2b_z[%0d]: got %h/%h/%b want %h/%h/%b", i, rd1_z, rd2_z, vld_z, e.d1z, e.d2z, e.vldz); end
      tick();
      n_cmp++; if (rc !== m_rc || lc !== m_lc || lc_z !== m_lc) begin n_bad++; $display("FAIL b2b_cnt[%0d]: got %h/%h want %h/%h", i, rc, lc, m_rc, m_lc); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; WB_EN = 1'b0; MEM_R_EN = 1'b0; cnt_clr = 1'b0;
    Val_LDR = 8'h00; ALU_Res = 8'h00; Dest = 2'd0; rd_addr1 = 2'd0; rd_addr2 = 2'd0;
    model_reset();
    test_reset();
    test_alu_write();
    test_load_write();
    test_gated_write();
    test_dual_read();
    test_counter_sat_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
